// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage and the stages that
// instantiate it.
//   OCC_W              - width of the occupancy count (0..2 entries)
//   CTRL_REGWRITE      - bit index of RegWrite inside the control bundle
//   CTRL_MEMREAD       - bit index of MemRead
//   CTRL_MEMWRITE      - bit index of MemWrite
//   CTRL_MEMTOREG_LSB  - low bit of the MemToReg select field
//   occ_count()        - number of valid entries from the two valid flags
package pipe_pkg;

  localparam int OCC_W             = 2;

  localparam int CTRL_REGWRITE     = 0;
  localparam int CTRL_MEMREAD      = 1;
  localparam int CTRL_MEMWRITE     = 2;
  localparam int CTRL_MEMTOREG_LSB = 3;

  function automatic logic [OCC_W-1:0] occ_count(input logic main_valid,
                                                 input logic skid_valid);
    return {1'b0, main_valid} + {1'b0, skid_valid};
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One storage slot of the elastic stage: valid flag, payload, control bundle
// and halt marker.
//   clk, rst     - clock and asynchronous active-low reset
//   load         - capture d_* and mark the slot valid
//   clear        - invalidate the slot; wins over load
//   d_data/d_ctrl/d_halt - word to capture
//   valid/data/ctrl/halt - slot contents
// Clearing zeroes ctrl and halt so an empty slot never presents a live
// RegWrite/MemWrite; data keeps its stale value since nobody qualifies on it.
module pipe_entry #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic              d_halt,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl,
  output logic              halt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
      halt  <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      halt  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d_data;
      ctrl  <= d_ctrl;
      halt  <= d_halt;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Generic elastic pipeline stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   clk, rst     - clock, asynchronous active-low reset
//   flush        - synchronous kill of every held entry
//   in_valid/in_ready/in_data/in_ctrl/in_halt - upstream side
//   out_valid/out_ready/out_data/out_ctrl/out_halt - downstream side
//   halted       - sticky: a HALT word has left the stage
//   occupancy    - number of valid entries (0..2)
//
// Handshake: a word moves across a port on a rising edge where valid and
// ready are both 1 (acc upstream, emit downstream). valid never depends on
// ready; a producer may change or drop an unaccepted word freely.
//
// SKID=1 keeps a second slot so in_ready comes straight from flops;
// SKID=0 uses one slot and lets out_ready pass through to in_ready.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_halt,
  output logic              halted,
  output logic [OCC_W-1:0]  occupancy
);

  logic              rst_done;
  logic              halt_pending;
  logic              acc;
  logic              emit;

  logic              m_valid, m_halt, m_load, m_clear;
  logic [DATA_W-1:0] m_data;
  logic [CTRL_W-1:0] m_ctrl;
  logic              m_src_halt;
  logic [DATA_W-1:0] m_src_data;
  logic [CTRL_W-1:0] m_src_ctrl;

  logic              s_valid, s_halt;
  logic [DATA_W-1:0] s_data;
  logic [CTRL_W-1:0] s_ctrl;

  // Holds in_ready low through reset and for the release edge itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_done <= 1'b0;
    else      rst_done <= 1'b1;
  end

  always_comb begin
    in_ready = 1'b0;
    if (SKID != 0)
      in_ready = rst_done & ~s_valid & ~halt_pending & ~halted;
    else
      in_ready = rst_done & (~m_valid | out_ready) & ~halt_pending & ~halted;
  end

  assign acc  = in_valid & in_ready;
  assign emit = m_valid & out_ready;

  // Main slot control. A skid word always refills main first on emit;
  // in_ready is low whenever skid is occupied, so acc cannot collide.
  always_comb begin
    m_load     = 1'b0;
    m_clear    = flush;
    m_src_data = in_data;
    m_src_ctrl = in_ctrl;
    m_src_halt = in_halt;
    if (SKID != 0) begin
      if (s_valid) begin
        m_src_data = s_data;
        m_src_ctrl = s_ctrl;
        m_src_halt = s_halt;
      end
      m_load  = (acc & (~m_valid | emit)) | (emit & s_valid);
      m_clear = flush | (emit & ~s_valid & ~acc);
    end else begin
      m_load  = acc;
      m_clear = flush | (emit & ~acc);
    end
  end

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (m_load),
    .clear  (m_clear),
    .d_data (m_src_data),
    .d_ctrl (m_src_ctrl),
    .d_halt (m_src_halt),
    .valid  (m_valid),
    .data   (m_data),
    .ctrl   (m_ctrl),
    .halt   (m_halt)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic s_load;
      logic s_clear;

      // Skid only catches a word that arrives while main is stuck.
      assign s_load  = acc & m_valid & ~emit;
      assign s_clear = flush | (emit & s_valid);

      pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (s_load),
        .clear  (s_clear),
        .d_data (in_data),
        .d_ctrl (in_ctrl),
        .d_halt (in_halt),
        .valid  (s_valid),
        .data   (s_data),
        .ctrl   (s_ctrl),
        .halt   (s_halt)
      );
    end else begin : g_no_skid
      assign s_valid = 1'b0;
      assign s_data  = '0;
      assign s_ctrl  = '0;
      assign s_halt  = 1'b0;
    end
  endgenerate

  // A HALT that is emitted in a flush cycle has still been delivered, so
  // halted sets regardless of flush and is only cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halt_pending <= 1'b0;
      halted       <= 1'b0;
    end else begin
      if (emit & m_halt) halted <= 1'b1;

      if (flush)               halt_pending <= 1'b0;
      else if (emit & m_halt)  halt_pending <= 1'b0;
      else if (acc & in_halt)  halt_pending <= 1'b1;
    end
  end

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_ctrl;
  assign out_halt  = m_halt;
  assign occupancy = occ_count(m_valid, s_valid);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: dut_a is the SKID=1 build, dut_b the SKID=0
// build. Each has a queue-based model of the words it holds; a compare
// process checks every output against the model mid-cycle.
module tb_pipe_stage_elastic;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int EW = DW + CW + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_flush, a_in_valid, a_in_ready, a_in_halt;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic          a_out_valid, a_out_ready, a_out_halt, a_halted;
  logic [1:0]    a_occ;

  logic          b_flush, b_in_valid, b_in_ready, b_in_halt;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic          b_out_valid, b_out_ready, b_out_halt, b_halted;
  logic [1:0]    b_occ;

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_ctrl(a_in_ctrl), .in_halt(a_in_halt),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_ctrl(a_out_ctrl), .out_halt(a_out_halt),
    .halted(a_halted), .occupancy(a_occ)
  );

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_ctrl(b_in_ctrl), .in_halt(b_in_halt),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_ctrl(b_out_ctrl), .out_halt(b_out_halt),
    .halted(b_halted), .occupancy(b_occ)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: words held, in order ----------------
  // Entry packing: {halt, ctrl, data}
  logic [EW-1:0] exp_q_a[$];
  logic [EW-1:0] exp_q_b[$];
  bit hp_a = 0, hd_a = 0, rd_a = 0;
  bit hp_b = 0, hd_b = 0, rd_b = 0;

  function automatic bit rdy_a();
    return rd_a && (exp_q_a.size() < 2) && !hp_a && !hd_a;
  endfunction

  function automatic bit rdy_b();
    return rd_b && (exp_q_b.size() == 0 || b_out_ready) && !hp_b && !hd_b;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q_a.delete(); hp_a = 0; hd_a = 0; rd_a = 0;
      exp_q_b.delete(); hp_b = 0; hd_b = 0; rd_b = 0;
    end else begin
      bit acc_a, emit_a, acc_b, emit_b;
      acc_a  = a_in_valid && rdy_a();
      emit_a = (exp_q_a.size() > 0) && a_out_ready;
      acc_b  = b_in_valid && rdy_b();
      emit_b = (exp_q_b.size() > 0) && b_out_ready;

      if (emit_a) begin
        if (exp_q_a[0][EW-1]) begin hd_a = 1; hp_a = 0; end
        void'(exp_q_a.pop_front());
      end
      if (a_flush) begin
        exp_q_a.delete(); hp_a = 0;
      end else if (acc_a) begin
        exp_q_a.push_back({a_in_halt, a_in_ctrl, a_in_data});
        if (a_in_halt) hp_a = 1;
      end
      rd_a = 1;

      if (emit_b) begin
        if (exp_q_b[0][EW-1]) begin hd_b = 1; hp_b = 0; end
        void'(exp_q_b.pop_front());
      end
      if (b_flush) begin
        exp_q_b.delete(); hp_b = 0;
      end else if (acc_b) begin
        exp_q_b.push_back({b_in_halt, b_in_ctrl, b_in_data});
        if (b_in_halt) hp_b = 1;
      end
      rd_b = 1;
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  always @(negedge clk) begin
    #2;
    check("a.in_ready", 32'(a_in_ready), 32'(rdy_a()));
    check("a.out_valid", 32'(a_out_valid), 32'(exp_q_a.size() > 0));
    check("a.occupancy", 32'(a_occ), 32'(exp_q_a.size()));
    check("a.halted", 32'(a_halted), 32'(hd_a));
    if (exp_q_a.size() > 0) begin
      check("a.out_data", 32'(a_out_data), 32'(exp_q_a[0][DW-1:0]));
      check("a.out_ctrl", 32'(a_out_ctrl), 32'(exp_q_a[0][DW+CW-1:DW]));
      check("a.out_halt", 32'(a_out_halt), 32'(exp_q_a[0][EW-1]));
    end else begin
      check("a.out_ctrl_bubble", 32'(a_out_ctrl), 32'd0);
      check("a.out_halt_bubble", 32'(a_out_halt), 32'd0);
    end

    check("b.in_ready", 32'(b_in_ready), 32'(rdy_b()));
    check("b.out_valid", 32'(b_out_valid), 32'(exp_q_b.size() > 0));
    check("b.occupancy", 32'(b_occ), 32'(exp_q_b.size()));
    check("b.halted", 32'(b_halted), 32'(hd_b));
    if (exp_q_b.size() > 0) begin
      check("b.out_data", 32'(b_out_data), 32'(exp_q_b[0][DW-1:0]));
      check("b.out_ctrl", 32'(b_out_ctrl), 32'(exp_q_b[0][DW+CW-1:DW]));
      check("b.out_halt", 32'(b_out_halt), 32'(exp_q_b[0][EW-1]));
    end else begin
      check("b.out_ctrl_bubble", 32'(b_out_ctrl), 32'd0);
      check("b.out_halt_bubble", 32'(b_out_halt), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_all();
    a_flush = 0; a_in_valid = 0; a_in_halt = 0; a_in_data = '0;
    a_in_ctrl = '0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_halt = 0; b_in_data = '0;
    b_in_ctrl = '0; b_out_ready = 0;
  endtask

  task automatic send_a(input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic h);
    a_in_valid = 1; a_in_data = d; a_in_ctrl = c; a_in_halt = h;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle_all();

    // Reset held with a word offered: nothing visible, in_ready low.
    send_a(16'h1234, 8'h05, 1'b0);
    repeat (3) tick();
    settle();
    check("lit.reset_in_ready", 32'(a_in_ready), 32'd0);
    check("lit.reset_out_valid", 32'(a_out_valid), 32'd0);
    check("lit.reset_out_data", 32'(a_out_data), 32'd0);
    check("lit.reset_out_ctrl", 32'(a_out_ctrl), 32'd0);
    check("lit.reset_occ", 32'(a_occ), 32'd0);
    check("lit.reset_b_in_ready", 32'(b_in_ready), 32'd0);

    // Release: in_ready rises one cycle later, word lands the cycle after.
    tick(); rst = 1'b1;
    tick(); settle();
    check("lit.release_in_ready", 32'(a_in_ready), 32'd1);
    check("lit.release_out_valid", 32'(a_out_valid), 32'd0);
    tick(); a_in_valid = 0; settle();
    check("lit.first_out_valid", 32'(a_out_valid), 32'd1);
    check("lit.first_out_data", 32'(a_out_data), 32'h1234);
    check("lit.first_out_ctrl", 32'(a_out_ctrl), 32'h05);
    tick(); a_out_ready = 1;
    tick(); a_out_ready = 0;

    // Fill both slots with downstream stalled, then drain in order.
    tick(); send_a(16'h0001, 8'h11, 1'b0);
    tick(); send_a(16'h0002, 8'h22, 1'b0);
    tick(); a_in_valid = 0; settle();
    check("lit.full_occ", 32'(a_occ), 32'd2);
    check("lit.full_in_ready", 32'(a_in_ready), 32'd0);
    check("lit.full_head", 32'(a_out_data), 32'h0001);
    a_out_ready = 1;
    tick(); settle();
    check("lit.drain_second", 32'(a_out_data), 32'h0002);
    check("lit.drain_second_ctrl", 32'(a_out_ctrl), 32'h22);
    tick(); a_out_ready = 0; settle();
    check("lit.drained_valid", 32'(a_out_valid), 32'd0);
    check("lit.drained_ctrl", 32'(a_out_ctrl), 32'd0);

    // Flush a full stage while C is offered: everything disappears.
    tick(); send_a(16'h0004, 8'h44, 1'b0);
    tick(); send_a(16'h0005, 8'h55, 1'b0);
    tick(); send_a(16'h0003, 8'h33, 1'b0); a_flush = 1; settle();
    check("lit.preflush_occ", 32'(a_occ), 32'd2);
    tick(); a_flush = 0; a_in_valid = 0; settle();
    check("lit.flush_occ", 32'(a_occ), 32'd0);
    check("lit.flush_valid", 32'(a_out_valid), 32'd0);
    check("lit.flush_ctrl", 32'(a_out_ctrl), 32'd0);
    a_out_ready = 1;
    repeat (2) tick();
    settle();
    check("lit.c_never_out", 32'(a_out_valid), 32'd0);
    a_out_ready = 0;

    // HALT accepted then flushed before emission: acceptance resumes.
    tick(); send_a(16'h0077, 8'h01, 1'b1);
    tick(); a_in_valid = 0; a_in_halt = 0; settle();
    check("lit.hp_in_ready", 32'(a_in_ready), 32'd0);
    check("lit.hp_occ", 32'(a_occ), 32'd1);
    tick(); a_flush = 1;
    tick(); a_flush = 0; settle();
    check("lit.hp_flushed_in_ready", 32'(a_in_ready), 32'd1);
    check("lit.hp_flushed_halted", 32'(a_halted), 32'd0);
    send_a(16'h00AA, 8'h0A, 1'b0);
    tick(); a_in_valid = 0; settle();
    check("lit.after_halt_flush_data", 32'(a_out_data), 32'h00AA);
    check("lit.after_halt_flush_valid", 32'(a_out_valid), 32'd1);
    a_out_ready = 1;
    tick(); a_out_ready = 0;

    // HALT emitted: halted sticks through a flush, nothing more accepted.
    tick(); send_a(16'h00FF, 8'h01, 1'b1);
    tick(); a_in_valid = 0; a_in_halt = 0; settle();
    check("lit.halt_in_ready", 32'(a_in_ready), 32'd0);
    check("lit.halt_out_halt", 32'(a_out_halt), 32'd1);
    a_out_ready = 1;
    tick(); a_out_ready = 0; settle();
    check("lit.halted_set", 32'(a_halted), 32'd1);
    check("lit.halted_out_valid", 32'(a_out_valid), 32'd0);
    tick(); a_flush = 1; send_a(16'h0099, 8'h09, 1'b0);
    tick(); a_flush = 0;
    tick(); settle();
    check("lit.halted_after_flush", 32'(a_halted), 32'd1);
    check("lit.halted_in_ready", 32'(a_in_ready), 32'd0);
    check("lit.halted_no_accept", 32'(a_out_valid), 32'd0);

    // Reset again and exercise the single-entry build.
    tick(); idle_all(); rst = 1'b0;
    tick(); rst = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      b_in_valid = 1; b_in_data = 16'(16'h0100 + i); b_in_ctrl = 8'(i);
      b_out_ready = (i % 2 == 0);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      b_in_valid = 1; b_in_data = 16'(16'h0200 + i); b_in_ctrl = 8'(8'h80 + i);
      b_out_ready = 1;
      settle();
      check("lit.b_stream_in_ready", 32'(b_in_ready), 32'd1);
      check("lit.b_stream_occ_le1", 32'(b_occ <= 2'd1), 32'd1);
      if (i > 0) check("lit.b_stream_data", 32'(b_out_data), 32'(16'h0200 + i - 1));
    end
    tick(); idle_all();

    // Randomised traffic on both builds, with periodic resets to leave
    // the halted state.
    for (int i = 0; i < 2000; i++) begin
      tick();
      rst = (i % 250 != 249);
      a_in_valid  = ($urandom_range(0, 9) < 7);
      a_in_data   = DW'($urandom);
      a_in_ctrl   = CW'($urandom);
      a_in_halt   = ($urandom_range(0, 199) == 0);
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_flush     = ($urandom_range(0, 31) == 0);
      b_in_valid  = ($urandom_range(0, 9) < 7);
      b_in_data   = DW'($urandom);
      b_in_ctrl   = CW'($urandom);
      b_in_halt   = ($urandom_range(0, 199) == 0);
      b_out_ready = ($urandom_range(0, 2) != 0);
      b_flush     = ($urandom_range(0, 31) == 0);
    end
    tick(); idle_all(); rst = 1'b1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed EX/MEM latch: a generic elastic pipeline stage register.
- Carries a DATA_W payload and a CTRL_W control bundle with valid/ready handshaking, an optional 2-entry skid buffer, synchronous flush and halt drain.
- Instantiated between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces per-field register instances and hand-built stall/flush reset gating.

Parameters:
- DATA_W, 16, payload width (ALU result, PC, write data, packed by the instantiating stage).
- CTRL_W, 8, control bundle width (RegWrite, MemRead, MemWrite, MemToReg, ...). Forced to 0 on any bubble.
- SKID, 1, 1 = two entries (main + skid) with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_halt  in  1  word is a HALT instruction.
- out_valid  out  1  held word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  held payload.
- out_ctrl  out  CTRL_W  held control; 0 when out_valid=0.
- out_halt  out  1  held word is HALT; 0 when out_valid=0.
- halted  out  1  sticky; a HALT word has left the stage.
- occupancy  out  2  number of valid entries, 0..2.

Behaviour:
- Reset (rst=0, async):
  - main_valid=0, skid_valid=0, halt_pending=0, halted=0.
  - All data and ctrl registers 0, so every output is 0.
  - in_ready=0 during reset; in_ready=1 on the first cycle after release.
- Handshake events:
  - acc = in_valid & in_ready.
  - emit = out_valid & out_ready.
  - Latency is 1 cycle from acc to out_valid.
  - in_valid/in_data may change without acc; only accepted words are stored.
- SKID=1:
  - in_ready = ~skid_valid & ~halt_pending & ~halted, purely from registered state.
  - acc with main empty, or main emitting: word loads main.
  - acc with main full and not emitting: word loads skid.
  - emit with skid_valid: skid moves to main, skid_valid clears. Simultaneous acc cannot occur because in_ready=0.
  - Full (occupancy 2): in_ready=0. Out order always equals acceptance order.
- SKID=0:
  - in_ready = (~main_valid | out_ready) & ~halt_pending & ~halted.
  - Skid registers absent; occupancy never exceeds 1.
- Flush (priority below reset, above everything else):
  - Next cycle: main_valid=0, skid_valid=0, held ctrl=0, halt_pending=0.
  - A word accepted in the flush cycle is discarded.
  - A word emitted in the flush cycle still counts as delivered downstream.
  - halted is never cleared by flush.
- Halt:
  - acc with in_halt=1 sets halt_pending. No further words are accepted.
  - emit of a word with out_halt=1 sets halted and clears halt_pending.
  - halted stays 1 until reset, so the stage accepts nothing more.
  - Flushing an un-emitted HALT clears halt_pending and resumes acceptance.
- Bubbles: ctrl and halt bits are zeroed on write whenever an entry is invalidated, so an invalid entry never drives RegWrite/MemWrite. Data bits may hold stale values.
- occupancy = main_valid + skid_valid, registered.
- Simultaneous flush + emit + acc: flush dominates the stored state.

Decomposition:
- Shared package pipe_pkg:
  - occupancy width constant OCC_W=2.
  - CTRL field index constants (CTRL_REGWRITE, CTRL_MEMREAD, CTRL_MEMWRITE, CTRL_MEMTOREG_LSB) used by the instantiating stages.
- One sub-module, pipe_entry: a single valid + data + ctrl + halt slot with load/clear controls and async active-low reset.
- Instantiated once for main, and once more for skid when SKID=1.

Test Plan:
- Reset with in_valid=1 → all outputs 0, in_ready=0. Release → in_ready=1 next cycle; data 16'h1234 ctrl 8'h05 accepted → next cycle out_valid=1, out_data=16'h1234, out_ctrl=8'h05.
- SKID=1, out_ready=0, send A=16'h0001 then B=16'h0002 → occupancy=2, in_ready=0. Raise out_ready → outputs A then B on consecutive cycles, then out_valid=0 and out_ctrl=0.
- Stage full, assert flush with in_valid=1 C=16'h0003 → next cycle occupancy=0, out_valid=0, out_ctrl=0; C never appears.
- Accept HALT word (in_halt=1) → in_ready=0 despite empty skid. Emit it → halted=1 and remains 1 through a later flush pulse.
- Accept HALT, flush before emit → halt_pending cleared, in_ready=1, halted=0; next word 16'h00AA flows normally.
- SKID=0, continuous in_valid with out_ready toggling 1,0,1,0 → one word per accepted cycle, no loss or duplication, occupancy ≤1, throughput 1/cycle when out_ready held 1.
